con_run_ctl: RTL and testbench
==============================

# con_run_ctl

Parametrised EBOX run/start control for the CON board. It decodes the console diagnostic control functions (clear run, set run, continue, and the new step-load) and generates the delayed RUN level and START pulse through a configurable-depth pipeline. It also holds the INSTR_GO and EBOX_HALTED state and the microcode state flags. New in this generation: a loadable single-instruction-step counter that drops RUN after N instruction boundaries, and a parametrised number of microcode state flags.

## Interface
Parameters:
- SYNC_DEPTH, 3: cycles from diag request to RUN/START change; legal range 1..8.
- STEP_W, 8: width of the step counter and of the step load data.
- NFLAGS, 4: number of microcode state flags; legal range 1..4.

Ports:
- clk  in  1  CON clock; the block has one clock.
- RESET  in  1  synchronous, active-high master reset.
- DIAG_CTL_FUNC_01x  in  1  diag control function strobe, one cycle wide.
- DS  in  3  diag function select, EBUS ds[4:6].
- EBUS_DATA  in  STEP_W  step count, sampled on a step-load.
- INSTR_DONE  in  1  instruction boundary pulse (NICOND dispatch).
- HALT_REQ  in  1  microcode halt request.
- COND_EBOX_STATE  in  1  update enable for the state flags.
- MAGIC  in  2*NFLAGS+1  CRAM magic bits [0:2*NFLAGS].
- RUN  out  1  delayed run level.
- START  out  1  one-cycle start pulse.
- INSTR_GO  out  1  instruction-go latch.
- EBOX_HALTED  out  1  halt latch.
- PI_DISABLE  out  1  ~RUN | EBOX_HALTED.
- STEP_ACTIVE  out  1  step mode is armed.
- STEP_CNT  out  STEP_W  remaining step count.
- UCODE_STATE  out  NFLAGS  microcode state flags; flag i is index i.

## Operation
- The diag decode is active only when DIAG_CTL_FUNC_01x=1:
  - DS=0 is CLR_RUN.
  - DS=1 is SET_RUN.
  - DS=2 is CONTINUE.
  - DS=3 is STEP_LOAD.
  - DS=4..7 are ignored; they belong to other blocks.
- Run latch R:
  - Set by SET_RUN.
  - Cleared by CLR_RUN, by step expiry, or by RESET.
  - If SET_RUN and step expiry occur in the same cycle, SET_RUN wins.
  - RUN is R delayed through SYNC_DEPTH-1 further flops.
- Start:
  - A CONTINUE arms a down-counter, and START pulses for exactly one cycle when it expires.
  - A CONTINUE that arrives while a start is already pending is ignored. The pending start is not restarted.
- INSTR_GO:
  - Set by CONTINUE.
  - Cleared by INSTR_DONE or RESET.
  - If CONTINUE and INSTR_DONE occur in the same cycle, the result is set.
- EBOX_HALTED:
  - Set by HALT_REQ.
  - Cleared by CONTINUE or RESET.
  - If HALT_REQ and CONTINUE occur in the same cycle, HALT_REQ wins.
- Step counter:
  - STEP_LOAD loads STEP_CNT from EBUS_DATA and sets STEP_ACTIVE = (EBUS_DATA != 0). Loading 0 selects free-run mode.
  - An INSTR_DONE with RUN=1 and STEP_ACTIVE=1 decrements STEP_CNT.
  - A decrement from 1 to 0 clears STEP_ACTIVE and causes step expiry, which clears R.
  - If STEP_LOAD and a decrement occur in the same cycle, the load wins.
  - STEP_CNT never wraps. At 0 with STEP_ACTIVE=0 there is no decrement.
- UCODE_STATE[i] updates only when COND_EBOX_STATE=1, using set = MAGIC[2i+1] and hold = MAGIC[2i+2]:
  - set=1 sets the flag to 1.
  - set=0 with hold=1 keeps the flag unchanged.
  - set=0 with hold=0 clears the flag to 0.
- RESET has priority over every other input. A RESET asserted mid-pipeline also cancels any pending START and any in-flight RUN change.

## Timing
- Every output is registered except PI_DISABLE, which is combinational from registered state.
- Reset values:
  - RUN, START, INSTR_GO, EBOX_HALTED, STEP_ACTIVE, STEP_CNT and UCODE_STATE are all 0.
  - PI_DISABLE is 1.
- RUN latency: for a request present in cycle T, RUN changes in cycle T+SYNC_DEPTH. The same applies to CLR_RUN and to step expiry, where T is the decrement cycle.
- START latency: for a CONTINUE in cycle T, START=1 only in cycle T+SYNC_DEPTH.
- INSTR_GO, EBOX_HALTED, STEP_CNT, STEP_ACTIVE and UCODE_STATE are visible in cycle T+1.
- INSTR_DONE pulses that arrive between expiry and the fall of RUN are not counted.

## Test plan
All scenarios use SYNC_DEPTH=3, STEP_W=8, NFLAGS=4.
- Reset: hold RESET for 2 cycles -> all outputs 0 and PI_DISABLE=1.
- Run: SET_RUN in cycle 10 -> RUN=1 from cycle 13. CLR_RUN in cycle 20 -> RUN=0 from cycle 23.
- Start: CONTINUE in cycle 5 with a repeat CONTINUE in cycle 6 -> START=1 only in cycle 8. INSTR_GO=1 from cycle 6 until the first INSTR_DONE. RESET in cycle 6 instead -> no START.
- Step mode, setup: RUN=1, then STEP_LOAD with EBUS_DATA=3.
  - Three INSTR_DONE pulses -> STEP_CNT goes 2, 1, 0 and STEP_ACTIVE drops with the third.
  - RUN=0 three cycles after the third pulse.
  - A fourth INSTR_DONE leaves STEP_CNT=0.
- Step mode, simultaneous events: STEP_LOAD=5 in the same cycle as a decrement -> STEP_CNT=5.
- Halt and state flags:
  - HALT_REQ together with CONTINUE -> EBOX_HALTED=1.
  - COND_EBOX_STATE with MAGIC=9'b0_10_01_00_10 (MAGIC[0:8] left to right) from 0000 -> UCODE_STATE = 1,0,0,1 (flags 0..3).

Source files
------------

// File: rtl/con_run_ctl_if.sv
// con_run_ctl_if: console diag, step, halt and ucode-state signals of the CON run/start control.
// The master drives the request side; the slave (con_run_ctl) drives the status side.
interface con_run_ctl_if #(
  parameter int STEP_W = 8,
  parameter int NFLAGS = 4
);
  logic                DIAG_CTL_FUNC_01x;
  logic [2:0]          DS;
  logic [STEP_W-1:0]   EBUS_DATA;
  logic                INSTR_DONE;
  logic                HALT_REQ;
  logic                COND_EBOX_STATE;
  // Bit j carries CRAM magic bit j; flag i uses set = bit 2i+1, hold = bit 2i+2.
  logic [2*NFLAGS:0]   MAGIC;

  logic                RUN;
  logic                START;
  logic                INSTR_GO;
  logic                EBOX_HALTED;
  logic                PI_DISABLE;
  logic                STEP_ACTIVE;
  logic [STEP_W-1:0]   STEP_CNT;
  logic [NFLAGS-1:0]   UCODE_STATE;

  modport master (
    output DIAG_CTL_FUNC_01x, DS, EBUS_DATA, INSTR_DONE, HALT_REQ, COND_EBOX_STATE, MAGIC,
    input  RUN, START, INSTR_GO, EBOX_HALTED, PI_DISABLE, STEP_ACTIVE, STEP_CNT, UCODE_STATE
  );

  modport slave (
    input  DIAG_CTL_FUNC_01x, DS, EBUS_DATA, INSTR_DONE, HALT_REQ, COND_EBOX_STATE, MAGIC,
    output RUN, START, INSTR_GO, EBOX_HALTED, PI_DISABLE, STEP_ACTIVE, STEP_CNT, UCODE_STATE
  );
endinterface

// File: rtl/con_run_ctl.sv
// con_run_ctl: EBOX run/start control for the CON board. Decodes console diag functions into a
// delayed RUN level and START pulse, and holds INSTR_GO, EBOX_HALTED, step count and ucode flags.
module con_run_ctl #(
  parameter int SYNC_DEPTH = 3,
  parameter int STEP_W     = 8,
  parameter int NFLAGS     = 4
) (
  input  logic         clk,
  input  logic         RESET,
  con_run_ctl_if.slave bus
);
  localparam int              CNT_W        = 4;
  localparam logic [CNT_W-1:0] START_LOAD  = 4'(SYNC_DEPTH - 1);
  localparam bit               DIRECT_START = (SYNC_DEPTH < 2);

  logic                  w_clr_run;
  logic                  w_set_run;
  logic                  w_continue;
  logic                  w_step_load;
  logic                  w_dec;
  logic                  w_expire;
  logic                  w_run_nxt;
  logic                  w_start_fire;
  logic [CNT_W-1:0]      w_start_cnt_nxt;
  logic [NFLAGS-1:0]     w_ucode_nxt;
  logic                  w_unused_magic0;

  logic [SYNC_DEPTH-1:0] r_run_pipe;
  logic [CNT_W-1:0]      r_start_cnt;
  logic                  r_start;
  logic                  r_instr_go;
  logic                  r_halted;
  logic                  r_step_active;
  logic [STEP_W-1:0]     r_step_cnt;
  logic [NFLAGS-1:0]     r_ucode;

  // Diag function decode; DS 4..7 belong to other CON functions and are ignored here.
  always_comb begin
    w_clr_run   = 1'b0;
    w_set_run   = 1'b0;
    w_continue  = 1'b0;
    w_step_load = 1'b0;
    if (bus.DIAG_CTL_FUNC_01x) begin
      case (bus.DS)
        3'd0:    w_clr_run   = 1'b1;
        3'd1:    w_set_run   = 1'b1;
        3'd2:    w_continue  = 1'b1;
        3'd3:    w_step_load = 1'b1;
        default: w_clr_run   = 1'b0;
      endcase
    end else begin
      w_clr_run = 1'b0;
    end
  end

  // Step decrement and expiry; a same-cycle load pre-empts both.
  always_comb begin
    w_dec    = bus.INSTR_DONE & r_run_pipe[SYNC_DEPTH-1] & r_step_active;
    w_expire = 1'b0;
    if (w_dec && !w_step_load && (r_step_cnt == STEP_W'(1))) begin
      w_expire = 1'b1;
    end else begin
      w_expire = 1'b0;
    end
  end

  // Run latch next value: SET_RUN beats both CLR_RUN and step expiry.
  always_comb begin
    w_run_nxt = r_run_pipe[0];
    if (w_set_run) begin
      w_run_nxt = 1'b1;
    end else if (w_clr_run || w_expire) begin
      w_run_nxt = 1'b0;
    end else begin
      w_run_nxt = r_run_pipe[0];
    end
  end

  // Start down-counter: non-zero means a start is pending, and further CONTINUEs are ignored.
  always_comb begin
    w_start_cnt_nxt = r_start_cnt;
    w_start_fire    = 1'b0;
    if (r_start_cnt != 4'd0) begin
      w_start_cnt_nxt = r_start_cnt - 4'd1;
      w_start_fire    = (r_start_cnt == 4'd1);
    end else if (w_continue) begin
      if (DIRECT_START) begin
        w_start_fire = 1'b1;
      end else begin
        w_start_cnt_nxt = START_LOAD;
      end
    end else begin
      w_start_cnt_nxt = 4'd0;
    end
  end

  // Ucode state flags: set wins, otherwise hold keeps, otherwise clear.
  always_comb begin
    w_ucode_nxt = r_ucode;
    for (int i = 0; i < NFLAGS; i++) begin
      if (!bus.COND_EBOX_STATE) begin
        w_ucode_nxt[i] = r_ucode[i];
      end else if (bus.MAGIC[2*i+1]) begin
        w_ucode_nxt[i] = 1'b1;
      end else if (bus.MAGIC[2*i+2]) begin
        w_ucode_nxt[i] = r_ucode[i];
      end else begin
        w_ucode_nxt[i] = 1'b0;
      end
    end
  end

  // Run latch followed by SYNC_DEPTH-1 delay flops; reset flushes any in-flight change.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_run_pipe <= '0;
    end else begin
      r_run_pipe[0] <= w_run_nxt;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_run_pipe[i] <= r_run_pipe[i-1];
      end
    end
  end

  // Start counter and registered START pulse.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_start_cnt <= 4'd0;
      r_start     <= 1'b0;
    end else begin
      r_start_cnt <= w_start_cnt_nxt;
      r_start     <= w_start_fire;
    end
  end

  // INSTR_GO (CONTINUE beats INSTR_DONE) and EBOX_HALTED (HALT_REQ beats CONTINUE).
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_instr_go <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_continue) begin
        r_instr_go <= 1'b1;
      end else if (bus.INSTR_DONE) begin
        r_instr_go <= 1'b0;
      end else begin
        r_instr_go <= r_instr_go;
      end
      if (bus.HALT_REQ) begin
        r_halted <= 1'b1;
      end else if (w_continue) begin
        r_halted <= 1'b0;
      end else begin
        r_halted <= r_halted;
      end
    end
  end

  // Step counter: load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_step_cnt    <= '0;
      r_step_active <= 1'b0;
    end else if (w_step_load) begin
      r_step_cnt    <= bus.EBUS_DATA;
      r_step_active <= (bus.EBUS_DATA != '0);
    end else if (w_dec && (r_step_cnt != '0)) begin
      r_step_cnt    <= r_step_cnt - STEP_W'(1);
      r_step_active <= ~w_expire;
    end else begin
      r_step_cnt    <= r_step_cnt;
      r_step_active <= r_step_active;
    end
  end

  // Ucode state flag register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_ucode <= '0;
    end else begin
      r_ucode <= w_ucode_nxt;
    end
  end

  assign w_unused_magic0 = bus.MAGIC[0];

  assign bus.RUN         = r_run_pipe[SYNC_DEPTH-1];
  assign bus.START       = r_start;
  assign bus.INSTR_GO    = r_instr_go;
  assign bus.EBOX_HALTED = r_halted;
  assign bus.PI_DISABLE  = ~r_run_pipe[SYNC_DEPTH-1] | r_halted;
  assign bus.STEP_ACTIVE = r_step_active;
  assign bus.STEP_CNT    = r_step_cnt;
  assign bus.UCODE_STATE = r_ucode;
endmodule

// File: tb/tb_con_run_ctl.sv
// tb_con_run_ctl: table-driven ucode-flag vectors through a scoreboard queue, plus hand-written
// cycle-accurate sequences for run/start latency, reset cancellation, step mode and halt.
module tb_con_run_ctl;
  logic clk;
  logic RESET;
  int   n_checks;
  int   n_fail;

  con_run_ctl_if #(.STEP_W(8), .NFLAGS(4)) bus ();

  con_run_ctl #(.SYNC_DEPTH(3), .STEP_W(8), .NFLAGS(4)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cond;
    logic [3:0] set;
    logic [3:0] hold;
    logic [3:0] exp;
  } flag_vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  flag_vec_t vecs [7];
  sb_t       sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic diag(input logic [2:0] ds, input logic [7:0] data);
    bus.DIAG_CTL_FUNC_01x = 1'b1;
    bus.DS = ds;
    bus.EBUS_DATA = data;
    step();
    bus.DIAG_CTL_FUNC_01x = 1'b0;
    bus.EBUS_DATA = 8'd0;
  endtask

  task automatic pulse_done();
    bus.INSTR_DONE = 1'b1;
    step();
    bus.INSTR_DONE = 1'b0;
  endtask

  function automatic logic [8:0] build_magic(input logic [3:0] s, input logic [3:0] h);
    logic [8:0] m;
    m = 9'b0_0000_0001;
    for (int i = 0; i < 4; i++) begin
      m[2*i+1] = s[i];
      m[2*i+2] = h[i];
    end
    return m;
  endfunction

  // Literal written MAGIC[0:8] left to right -> bit j = MAGIC[j].
  function automatic logic [8:0] spec_order(input logic [8:0] lit);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = lit[8-i];
    return r;
  endfunction

  initial begin
    sb_t e;
    n_checks = 0;
    n_fail   = 0;
    // cond, set, hold, expected flags (bit i = flag i), starting from 0000
    vecs[0] = '{1'b1, 4'b1001, 4'b0010, 4'b1001};
    vecs[1] = '{1'b0, 4'b0110, 4'b0000, 4'b1001};
    vecs[2] = '{1'b1, 4'b0000, 4'b1111, 4'b1001};
    vecs[3] = '{1'b1, 4'b0110, 4'b1000, 4'b1110};
    vecs[4] = '{1'b1, 4'b0000, 4'b0101, 4'b0100};
    vecs[5] = '{1'b1, 4'b1111, 4'b0000, 4'b1111};
    vecs[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};

    bus.DIAG_CTL_FUNC_01x = 1'b0;
    bus.DS = 3'd0;
    bus.EBUS_DATA = 8'd0;
    bus.INSTR_DONE = 1'b0;
    bus.HALT_REQ = 1'b0;
    bus.COND_EBOX_STATE = 1'b0;
    bus.MAGIC = 9'd0;
    RESET = 1'b1;
    step();
    step();
    chk("rst_run", 32'(bus.RUN), 32'd0);
    chk("rst_start", 32'(bus.START), 32'd0);
    chk("rst_instr_go", 32'(bus.INSTR_GO), 32'd0);
    chk("rst_halted", 32'(bus.EBOX_HALTED), 32'd0);
    chk("rst_step_active", 32'(bus.STEP_ACTIVE), 32'd0);
    chk("rst_step_cnt", 32'(bus.STEP_CNT), 32'd0);
    chk("rst_ucode", 32'(bus.UCODE_STATE), 32'd0);
    chk("rst_pi_disable", 32'(bus.PI_DISABLE), 32'd1);
    RESET = 1'b0;

    // Ucode flag vectors through the scoreboard.
    for (int v = 0; v < 7; v++) begin
      bus.COND_EBOX_STATE = vecs[v].cond;
      bus.MAGIC = build_magic(vecs[v].set, vecs[v].hold);
      sb_q.push_back('{$sformatf("ucode_vec%0d", v), 32'(vecs[v].exp)});
      step();
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk(e.name, 32'(bus.UCODE_STATE), e.exp);
      end
    end
    bus.COND_EBOX_STATE = 1'b1;
    bus.MAGIC = spec_order(9'b0_10_01_00_10);
    step();
    bus.COND_EBOX_STATE = 1'b0;
    bus.MAGIC = 9'd0;
    chk("ucode_literal", 32'(bus.UCODE_STATE), 32'b1001);

    // SET_RUN in cycle T -> RUN from T+3; CLR_RUN likewise.
    diag(3'd1, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("run_set_k%0d", k), 32'(bus.RUN), 32'(k >= 3));
      step();
    end
    diag(3'd0, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("run_clr_k%0d", k), 32'(bus.RUN), 32'(k < 3));
      step();
    end

    // CONTINUE in T, repeat in T+1 -> START only in T+3.
    bus.DIAG_CTL_FUNC_01x = 1'b1;
    bus.DS = 3'd2;
    step();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("start_k%0d", k), 32'(bus.START), 32'(k == 3));
      if (k == 1) chk("instr_go_set", 32'(bus.INSTR_GO), 32'd1);
      step();
      bus.DIAG_CTL_FUNC_01x = 1'b0;
    end
    chk("instr_go_hold", 32'(bus.INSTR_GO), 32'd1);
    pulse_done();
    chk("instr_go_clr", 32'(bus.INSTR_GO), 32'd0);

    // RESET right after CONTINUE / SET_RUN cancels the pending change.
    diag(3'd2, 8'd0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      chk($sformatf("rst_start_cancel_k%0d", k), 32'(bus.START), 32'd0);
      step();
    end
    diag(3'd1, 8'd0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("rst_run_cancel_k%0d", k), 32'(bus.RUN), 32'd0);
      step();
    end

    // Step mode: load 3, three boundaries, then RUN falls 3 cycles after the last.
    diag(3'd1, 8'd0);
    step();
    step();
    chk("step_run_up", 32'(bus.RUN), 32'd1);
    diag(3'd3, 8'd3);
    chk("step_load_cnt", 32'(bus.STEP_CNT), 32'd3);
    chk("step_load_act", 32'(bus.STEP_ACTIVE), 32'd1);
    pulse_done();
    chk("step_cnt2", 32'(bus.STEP_CNT), 32'd2);
    step();
    pulse_done();
    chk("step_cnt1", 32'(bus.STEP_CNT), 32'd1);
    chk("step_act1", 32'(bus.STEP_ACTIVE), 32'd1);
    pulse_done();
    chk("step_cnt0", 32'(bus.STEP_CNT), 32'd0);
    chk("step_act0", 32'(bus.STEP_ACTIVE), 32'd0);
    chk("step_run_e1", 32'(bus.RUN), 32'd1);
    pulse_done();
    chk("step_gap_cnt", 32'(bus.STEP_CNT), 32'd0);
    chk("step_run_e2", 32'(bus.RUN), 32'd1);
    step();
    chk("step_run_e3", 32'(bus.RUN), 32'd0);
    pulse_done();
    chk("step_no_wrap", 32'(bus.STEP_CNT), 32'd0);

    // Load beats a same-cycle decrement; SET_RUN beats a same-cycle expiry.
    diag(3'd1, 8'd0);
    step();
    step();
    diag(3'd3, 8'd3);
    bus.INSTR_DONE = 1'b1;
    diag(3'd3, 8'd5);
    bus.INSTR_DONE = 1'b0;
    chk("load_wins_cnt", 32'(bus.STEP_CNT), 32'd5);
    chk("load_wins_act", 32'(bus.STEP_ACTIVE), 32'd1);
    pulse_done();
    chk("dec_after_load", 32'(bus.STEP_CNT), 32'd4);
    diag(3'd3, 8'd1);
    bus.INSTR_DONE = 1'b1;
    diag(3'd1, 8'd0);
    bus.INSTR_DONE = 1'b0;
    chk("setrun_exp_cnt", 32'(bus.STEP_CNT), 32'd0);
    chk("setrun_exp_act", 32'(bus.STEP_ACTIVE), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("setrun_wins_k%0d", k), 32'(bus.RUN), 32'd1);
      step();
    end
    diag(3'd3, 8'd0);
    chk("freerun_act", 32'(bus.STEP_ACTIVE), 32'd0);
    pulse_done();
    chk("freerun_cnt", 32'(bus.STEP_CNT), 32'd0);

    // DS 4..7 are not ours.
    for (int ds = 4; ds < 8; ds++) diag(3'(ds), 8'h77);
    step();
    step();
    step();
    chk("ign_run", 32'(bus.RUN), 32'd1);
    chk("ign_cnt", 32'(bus.STEP_CNT), 32'd0);
    chk("ign_go", 32'(bus.INSTR_GO), 32'd0);
    chk("ign_start", 32'(bus.START), 32'd0);
    chk("pi_dis_run", 32'(bus.PI_DISABLE), 32'd0);

    // Halt: HALT_REQ beats CONTINUE; CONTINUE beats INSTR_DONE for INSTR_GO.
    bus.HALT_REQ = 1'b1;
    step();
    bus.HALT_REQ = 1'b0;
    chk("halt_set", 32'(bus.EBOX_HALTED), 32'd1);
    chk("pi_dis_halt", 32'(bus.PI_DISABLE), 32'd1);
    bus.HALT_REQ = 1'b1;
    diag(3'd2, 8'd0);
    bus.HALT_REQ = 1'b0;
    chk("halt_wins", 32'(bus.EBOX_HALTED), 32'd1);
    chk("go_with_halt", 32'(bus.INSTR_GO), 32'd1);
    bus.INSTR_DONE = 1'b1;
    diag(3'd2, 8'd0);
    bus.INSTR_DONE = 1'b0;
    chk("go_beats_done", 32'(bus.INSTR_GO), 32'd1);
    chk("halt_clr", 32'(bus.EBOX_HALTED), 32'd0);
    chk("pi_dis_clr", 32'(bus.PI_DISABLE), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
